// File: rtl/shared_mem_ctrl.sv
// Shared instruction/data memory responder for the multi-cycle CPU.
// Serves one MemRead/MemWrite request at a time with a fixed access latency and a one-cycle ready pulse.
module shared_mem_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_err,
  input  logic [DEPTH_LOG2-1:0] i_dbg_addr,
  output logic [31:0]           o_dbg_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [31:0]           r_mem [DEPTH];
  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic                  r_is_write;
  logic                  r_reject;
  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic                  r_err;
  logic                  r_busy;

  logic [1:0]            w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_capture;
  logic                  w_done;
  logic                  w_commit_wr;
  logic                  w_unused_addr;

  // Upper address bits only select aliases of the same word.
  assign w_unused_addr = ^i_addr[31:DEPTH_LOG2+2];

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_mem_read || i_mem_write) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, request capture and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_reject   <= 1'b0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_ready <= w_done;
      r_err   <= w_done & r_reject;
      if (w_capture) begin
        r_idx      <= i_addr[DEPTH_LOG2+1:2];
        r_wdata    <= i_wdata;
        r_is_write <= i_mem_write;
        r_reject   <= (i_addr[1:0] != 2'b00) || (i_mem_read && i_mem_write);
      end
      if (w_done && !r_reject && !r_is_write) begin
        r_rdata <= r_mem[r_idx];
      end
    end
  end

  // Array is not reset; a reset on the commit edge suppresses the write.
  assign w_commit_wr = w_done & ~i_rst & r_is_write & ~r_reject;

  always_ff @(posedge i_clk) begin
    if (w_commit_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign o_rdata    = r_rdata;
  assign o_ready    = r_ready;
  assign o_err      = r_err;
  assign o_busy     = r_busy;
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Self-checking bench for shared_mem_ctrl: table-driven requests with a response scoreboard,
// plus held-request and reset-abort sequences.
module tb_shared_mem_ctrl;

  localparam int unsigned DL  = 9;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_mem_read;
  logic          i_mem_write;
  logic [31:0]   i_addr;
  logic [31:0]   i_wdata;
  logic [31:0]   o_rdata;
  logic          o_ready;
  logic          o_busy;
  logic          o_err;
  logic [DL-1:0] i_dbg_addr;
  logic [31:0]   o_dbg_data;

  always #5 clk = ~clk;

  shared_mem_ctrl #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_mem_read (i_mem_read),
    .i_mem_write(i_mem_write),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_err      (o_err),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  typedef struct {
    logic          rd;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [DL-1:0] dbg;
    logic          exp_err;
    logic [31:0]   exp_rdata;
    logic [31:0]   exp_dbg;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb_q[$];
  resp_t mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;
  vec_t  vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic err, input logic [31:0] rdata);
    resp_t e;
    e.err   = err;
    e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  // Response monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (o_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_ready: got ready=1 expected no response");
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_err", 32'(o_err), 32'(mon_e.err));
        check("resp_rdata", o_rdata, mon_e.rdata);
      end
    end
  end

  // Issues one request from the low clock phase and waits (bounded) for its response.
  task automatic run_req(input vec_t v, input int idx);
    int lat;
    int nbusy;
    i_dbg_addr  = v.dbg;
    i_mem_read  = v.rd;
    i_mem_write = v.wr;
    i_addr      = v.addr;
    i_wdata     = v.wdata;
    push_exp(v.exp_err, v.exp_rdata);
    @(posedge clk);
    #1;
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
    i_addr      = $urandom;
    i_wdata     = $urandom;
    lat   = 0;
    nbusy = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      #1;
      if (o_busy === 1'b1) nbusy++;
      if (sb_q.size() == 0) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL vec%0d_timeout: got no ready in 20 cycles expected ready", idx);
      sb_q.delete();
    end
    check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(LAT + 1));
    check($sformatf("vec%0d_busy_cycles", idx), 32'(nbusy), 32'(LAT + 1));
    check($sformatf("vec%0d_dbg", idx), o_dbg_data, v.exp_dbg);
    @(negedge clk);
    #1;
    check($sformatf("vec%0d_ready_low", idx), 32'(o_ready), 32'd0);
    check($sformatf("vec%0d_busy_low", idx), 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [15:0] mask;

    //          rd    wr    addr          wdata         dbg      err   rdata         dbg_data
    vecs[0]  = '{1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF, 9'd4,   1'b0, 32'h00000000, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 32'h00000010, 32'h00000000, 9'd4,   1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h00000014, 32'h00001234, 9'd5,   1'b0, 32'hDEADBEEF, 32'h00001234};
    vecs[3]  = '{1'b1, 1'b0, 32'h00000014, 32'h00000000, 9'd5,   1'b0, 32'h00001234, 32'h00001234};
    vecs[4]  = '{1'b1, 1'b0, 32'h00000013, 32'h00000000, 9'd4,   1'b1, 32'h00001234, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 1'b1, 32'h00000013, 32'hFFFFFFFF, 9'd4,   1'b1, 32'h00001234, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b1, 32'h00000020, 32'h11111111, 9'd8,   1'b0, 32'h00001234, 32'h11111111};
    vecs[7]  = '{1'b1, 1'b1, 32'h00000020, 32'h00000055, 9'd8,   1'b1, 32'h00001234, 32'h11111111};
    vecs[8]  = '{1'b0, 1'b1, 32'h00000800, 32'hA5A5A5A5, 9'd0,   1'b0, 32'h00001234, 32'hA5A5A5A5};
    vecs[9]  = '{1'b1, 1'b0, 32'h00000000, 32'h00000000, 9'd0,   1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[10] = '{1'b0, 1'b1, 32'h000007FC, 32'hCAFEF00D, 9'd511, 1'b0, 32'hA5A5A5A5, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFFF7FC, 32'h00000000, 9'd511, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 1'b1, 32'h00000004, 32'h0BADC0DE, 9'd1,   1'b0, 32'hCAFEF00D, 32'h0BADC0DE};
    vecs[13] = '{1'b0, 1'b1, 32'h00000008, 32'h22222222, 9'd2,   1'b0, 32'hCAFEF00D, 32'h22222222};

    i_rst       = 1'b1;
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
    i_addr      = '0;
    i_wdata     = '0;
    i_dbg_addr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_rdata", o_rdata, 32'h0);
    check("reset_ready", 32'(o_ready), 32'd0);
    check("reset_err", 32'(o_err), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    i_rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_req(vecs[i], i);
    end

    // Held read: re-accepted every LATENCY+2 edges; address change in ACCESS does not affect the first response.
    push_exp(1'b0, 32'hA5A5A5A5);
    push_exp(1'b0, 32'h0BADC0DE);
    push_exp(1'b0, 32'h0BADC0DE);
    i_mem_read = 1'b1;
    i_addr     = 32'h0;
    mask       = '0;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      #1;
      if (o_ready === 1'b1) mask[c] = 1'b1;
      if (c == 1) i_addr = 32'h4;
      if (c == 11) i_mem_read = 1'b0;
    end
    check("held_ready_pattern", 32'(mask), 32'h0888);
    check("held_responses_left", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    @(negedge clk);
    #1;
    check("held_busy_low", 32'(o_busy), 32'd0);

    // Reset during ACCESS (d=1) and on the commit edge (d=2) aborts the write.
    for (int d = 1; d <= 2; d++) begin
      i_dbg_addr  = 9'd2;
      i_mem_write = 1'b1;
      i_addr      = 32'h8;
      i_wdata     = (d == 1) ? 32'h00000077 : 32'h00000099;
      @(posedge clk);
      #1;
      i_mem_write = 1'b0;
      if (d == 2) begin
        @(posedge clk);
        #1;
      end
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      @(negedge clk);
      #1;
      check($sformatf("rst%0d_ready", d), 32'(o_ready), 32'd0);
      check($sformatf("rst%0d_err", d), 32'(o_err), 32'd0);
      check($sformatf("rst%0d_busy", d), 32'(o_busy), 32'd0);
      check($sformatf("rst%0d_rdata", d), o_rdata, 32'h0);
      repeat (4) @(negedge clk);
      #1;
      check($sformatf("rst%0d_word2", d), o_dbg_data, 32'h22222222);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
